// File: rtl/alu_pkg.sv
// alu_pkg: opcodes, FSM states and helpers shared by the
// execute-stage ALU and its iterative mul/div unit.
package alu_pkg;

  localparam logic [3:0] OP_AND  = 4'b0000;
  localparam logic [3:0] OP_OR   = 4'b0001;
  localparam logic [3:0] OP_ADD  = 4'b0010;
  localparam logic [3:0] OP_MUL  = 4'b0011;
  localparam logic [3:0] OP_DIVU = 4'b0100;
  localparam logic [3:0] OP_REMU = 4'b0101;
  localparam logic [3:0] OP_SUB  = 4'b0110;
  localparam logic [3:0] OP_SLTU = 4'b0111;
  localparam logic [3:0] OP_SLT  = 4'b1000;
  localparam logic [3:0] OP_XOR  = 4'b1001;
  localparam logic [3:0] OP_SLL  = 4'b1010;
  localparam logic [3:0] OP_SRL  = 4'b1011;
  localparam logic [3:0] OP_NOR  = 4'b1100;
  localparam logic [3:0] OP_SRA  = 4'b1101;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } state_t;

  function automatic logic is_multicycle(
    input logic [3:0] op
  );
    return (op == OP_MUL) ||
           (op == OP_DIVU) ||
           (op == OP_REMU);
  endfunction

endpackage

// File: rtl/alu_muldiv_iter.sv
// alu_muldiv_iter: one-bit-per-cycle shift-add multiply and
// restoring unsigned divide; res is the value after this step.
module alu_muldiv_iter
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             en,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             done,
  output logic [WIDTH-1:0] res
);

  localparam int CW = $clog2(WIDTH);

  logic [CW-1:0]    cnt;
  logic [3:0]       op_q;
  logic [WIDTH-1:0] x_q, y_q, z_q;
  logic [WIDTH-1:0] x_n, y_n, z_n;
  logic [WIDTH:0]   rsh, diff;

  // mul: x=multiplicand, y=multiplier, z=product
  // div: x=divisor, y=dividend->quotient, z=remainder
  always_comb begin
    x_n  = x_q;
    y_n  = y_q;
    z_n  = z_q;
    rsh  = {z_q, y_q[WIDTH-1]};
    diff = rsh - {1'b0, x_q};
    if (op_q == OP_MUL) begin
      z_n = z_q + (y_q[0] ? x_q : '0);
      x_n = x_q << 1;
      y_n = y_q >> 1;
    end else begin
      z_n = diff[WIDTH] ? rsh[WIDTH-1:0]
                        : diff[WIDTH-1:0];
      y_n = {y_q[WIDTH-2:0], ~diff[WIDTH]};
    end
  end

  assign done = (cnt == '0);
  assign res  = (op_q == OP_DIVU) ? y_n : z_n;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt  <= '0;
      op_q <= OP_MUL;
      x_q  <= '0;
      y_q  <= '0;
      z_q  <= '0;
    end else if (start) begin
      cnt  <= CW'(WIDTH - 1);
      op_q <= op;
      x_q  <= (op == OP_MUL) ? a : b;
      y_q  <= (op == OP_MUL) ? b : a;
      z_q  <= '0;
    end else if (en) begin
      if (cnt != '0) cnt <= cnt - 1'b1;
      x_q <= x_n;
      y_q <= y_n;
      z_q <= z_n;
    end
  end

endmodule

// File: rtl/alu_seq.sv
// alu_seq: handshaked execute-stage ALU with registered result.
// ALU_SEQ_MULDIV_EN compiles in iterative MUL/DIVU/REMU.
module alu_seq
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  input  logic [3:0]       operation,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out,
  output logic             zero,
  output logic             illegal
);

  localparam int SW = $clog2(WIDTH);

  state_t           state, state_n, acc_st;
  logic             accept, sc_take;
  logic [WIDTH-1:0] sc_res;
  logic             sc_ill;
  logic [SW-1:0]    shamt;

  assign shamt = in2[SW-1:0];

  always_comb begin
    sc_res = '0;
    sc_ill = 1'b0;
    unique case (operation)
      OP_AND:  sc_res = in1 & in2;
      OP_OR:   sc_res = in1 | in2;
      OP_ADD:  sc_res = in1 + in2;
      OP_SUB:  sc_res = in1 - in2;
      OP_SLTU: sc_res = {{(WIDTH-1){1'b0}}, in1 < in2};
      OP_SLT:  sc_res = {{(WIDTH-1){1'b0}},
                         $signed(in1) < $signed(in2)};
      OP_XOR:  sc_res = in1 ^ in2;
      OP_NOR:  sc_res = ~(in1 | in2);
      OP_SLL:  sc_res = in1 << shamt;
      OP_SRL:  sc_res = in1 >> shamt;
      OP_SRA:  sc_res = $signed(in1) >>> shamt;
`ifdef ALU_SEQ_MULDIV_EN
      OP_MUL, OP_DIVU, OP_REMU: sc_res = '0;
`endif
      default: sc_ill = 1'b1;
    endcase
  end

`ifdef ALU_SEQ_MULDIV_EN
  logic             mc, md_done;
  logic [WIDTH-1:0] md_res;

  assign mc       = is_multicycle(operation);
  assign acc_st   = mc ? BUSY : DONE;
  assign sc_take  = accept & ~mc;
  assign in_ready = ~flush &
                    ((state == IDLE) |
                     ((state == DONE) & out_ready));

  alu_muldiv_iter #(.WIDTH(WIDTH)) u_muldiv (
    .clk   (clk),
    .rst_n (rst_n),
    .start (accept & mc),
    .en    (state == BUSY),
    .op    (operation),
    .a     (in1),
    .b     (in2),
    .done  (md_done),
    .res   (md_res)
  );
`else
  assign acc_st   = DONE;
  assign sc_take  = accept;
  assign in_ready = ~flush & ((state == IDLE) | out_ready);
`endif

  assign accept    = in_valid & in_ready;
  assign out_valid = (state == DONE);

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE: if (accept) state_n = acc_st;
`ifdef ALU_SEQ_MULDIV_EN
      BUSY: if (md_done) state_n = DONE;
`endif
      DONE: begin
        if (accept)         state_n = acc_st;
        else if (out_ready) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
    if (flush) state_n = IDLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      out     <= '0;
      zero    <= 1'b0;
      illegal <= 1'b0;
    end else begin
      state <= state_n;
      if (sc_take) begin
        out     <= sc_res;
        zero    <= (sc_res == '0);
        illegal <= sc_ill;
      end
`ifdef ALU_SEQ_MULDIV_EN
      else if ((state == BUSY) & md_done & ~flush) begin
        out     <= md_res;
        zero    <= (md_res == '0);
        illegal <= 1'b0;
      end
`endif
    end
  end

endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: directed and randomized checks of alu_seq against a
// transaction-level model of results and handshake timing.
`timescale 1ns/1ps
module tb_alu_seq;

  localparam int W = 32;
`ifdef ALU_SEQ_MULDIV_EN
  localparam bit MD = 1'b1;
`else
  localparam bit MD = 1'b0;
`endif

  logic         clk, rst_n, in_valid, flush, out_ready;
  logic         in_ready, out_valid, zero, illegal;
  logic [W-1:0] in1, in2, out;
  logic [3:0]   operation;

  int checks = 0;
  int errors = 0;

  alu_seq #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in1       (in1),
    .in2       (in2),
    .operation (operation),
    .flush     (flush),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out       (out),
    .zero      (zero),
    .illegal   (illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---- reference model: result and remaining stall cycles
  bit           m_valid = 1'b0;
  int           m_busy  = 0;
  logic [W-1:0] m_out   = '0;
  logic [W-1:0] m_pend  = '0;
  bit           m_ill   = 1'b0;

  function automatic bit is_mc(input logic [3:0] op);
    return MD && (op == 4'd3 || op == 4'd4 || op == 4'd5);
  endfunction

  // returns {illegal, result}
  function automatic logic [W:0] ref_op(
    input logic [3:0] op,
    input logic [W-1:0] a,
    input logic [W-1:0] b
  );
    int           sh;
    logic [W-1:0] r;
    logic [W-1:0] sgn;
    bit           ill;
    sh  = int'(b[4:0]);
    r   = '0;
    ill = 1'b0;
    sgn = 32'h8000_0000;
    case (op)
      4'd0:  r = a & b;
      4'd1:  r = a | b;
      4'd2:  r = a + b;
      4'd6:  r = a - b;
      4'd7:  r = {{(W-1){1'b0}}, a < b};
      4'd8:  r = {{(W-1){1'b0}}, (a ^ sgn) < (b ^ sgn)};
      4'd9:  r = a ^ b;
      4'd12: r = ~(a | b);
      4'd10: r = a << sh;
      4'd11: r = a >> sh;
      4'd13: r = (a >> sh) |
                 ({W{a[W-1]}} & ~({W{1'b1}} >> sh));
      4'd3:  if (MD) r = a * b; else ill = 1'b1;
      4'd4:  if (MD) r = (b == 0) ? '1 : a / b;
             else ill = 1'b1;
      4'd5:  if (MD) r = (b == 0) ? a : a % b;
             else ill = 1'b1;
      default: ill = 1'b1;
    endcase
    return {ill, r};
  endfunction

  function automatic bit exp_ready();
    return !flush && m_busy == 0 && (!m_valid || out_ready);
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_valid = 1'b0;
      m_busy  = 0;
      m_out   = '0;
      m_ill   = 1'b0;
    end else begin : step
      bit         rdy;
      logic [W:0] r;
      rdy = exp_ready();
      if (flush) begin
        m_valid = 1'b0;
        m_busy  = 0;
      end else if (m_busy > 0) begin
        m_busy--;
        if (m_busy == 0) begin
          m_valid = 1'b1;
          m_out   = m_pend;
          m_ill   = 1'b0;
        end
      end else if (in_valid && rdy) begin
        r = ref_op(operation, in1, in2);
        if (is_mc(operation)) begin
          m_busy  = W;
          m_valid = 1'b0;
          m_pend  = r[W-1:0];
        end else begin
          m_valid = 1'b1;
          m_out   = r[W-1:0];
          m_ill   = r[W];
        end
      end else if (m_valid && out_ready) begin
        m_valid = 1'b0;
      end
    end
  end

  task automatic chk(input string name,
                     input logic [W-1:0] act,
                     input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h at %0t",
               name, act, exp, $time);
    end
  endtask

  // ---- per-cycle compare against the model
  always @(negedge clk) begin
    chk("in_ready", in_ready, exp_ready());
    chk("out_valid", out_valid, m_valid);
    if (m_valid) begin
      chk("out", out, m_out);
      chk("zero", zero, m_out == 0);
      chk("illegal", illegal, m_ill);
    end
  end

  // ---- stimulus helpers
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input bit v, input logic [3:0] op,
                       input logic [W-1:0] a,
                       input logic [W-1:0] b);
    in_valid  = v;
    operation = op;
    in1       = a;
    in2       = b;
  endtask

  task automatic issue(input string name, input logic [3:0] op,
                       input logic [W-1:0] a,
                       input logic [W-1:0] b);
    int n;
    n = 0;
    drive(1'b1, op, a, b);
    @(negedge clk);
    while (!in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk({name, "_acc"}, in_ready, 1);
    tick();
    drive(1'b0, 4'd0, '0, '0);
  endtask

  task automatic wait_valid(input string name);
    int n;
    n = 0;
    @(negedge clk);
    while (!out_valid && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk({name, "_valid"}, out_valid, 1);
  endtask

  task automatic op_check(input string name, input logic [3:0] op,
                          input logic [W-1:0] a,
                          input logic [W-1:0] b,
                          input logic [W-1:0] exp,
                          input bit exp_ill);
    issue(name, op, a, b);
    wait_valid(name);
    chk(name, out, exp);
    chk({name, "_ill"}, illegal, exp_ill);
  endtask

  function automatic logic [W-1:0] rnd();
    case ($urandom_range(0, 4))
      0: return '0;
      1: return W'($urandom_range(0, 40));
      2: return ($urandom_range(0, 1) != 0) ? 32'hFFFF_FFFF
                                           : 32'h8000_0000;
      default: return W'($urandom());
    endcase
  endfunction

  initial begin
    int lat, stall, seen;
    rst_n     = 1'b0;
    flush     = 1'b0;
    out_ready = 1'b1;
    drive(1'b0, 4'd0, '0, '0);

    // reset values
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_out", out, 0);
    chk("rst_zero", zero, 0);
    chk("rst_ill", illegal, 0);
    chk("rst_rdy", in_ready, 1);
    tick();
    rst_n = 1'b1;

    // ADD then SUB back-to-back
    drive(1'b1, 4'd2, 32'hFFFF_FFFF, 32'h1);
    tick();
    drive(1'b1, 4'd6, 32'd5, 32'd7);
    @(negedge clk);
    chk("add_valid", out_valid, 1);
    chk("add_out", out, 0);
    chk("add_zero", zero, 1);
    tick();
    drive(1'b0, 4'd0, '0, '0);
    @(negedge clk);
    chk("sub_valid", out_valid, 1);
    chk("sub_out", out, 32'hFFFF_FFFE);
    chk("sub_zero", zero, 0);
    tick();

    op_check("sltu", 4'd7, 32'hFFFF_FFFF, 32'd1, 32'd0, 1'b0);
    op_check("slt", 4'd8, 32'hFFFF_FFFF, 32'd1, 32'd1, 1'b0);
    op_check("sra", 4'd13, 32'h8000_0000, 32'h24,
             32'hF800_0000, 1'b0);
    op_check("op1111", 4'd15, 32'd5, 32'd5, 32'd0, 1'b1);

    // MUL latency and stall
    issue("mul", 4'd3, 32'h0001_0003, 32'h0000_0010);
    lat   = 0;
    stall = 0;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      if (out_valid) begin
        lat = i;
        break;
      end
      if (!in_ready) stall++;
    end
    chk("mul_lat", lat, MD ? 33 : 1);
    chk("mul_stall", stall, MD ? 32 : 0);
    chk("mul_out", out, MD ? 32'h0010_0030 : 32'h0);
    chk("mul_ill", illegal, !MD);
    tick();

    op_check("divu", 4'd4, 32'd100, 32'd7,
             MD ? 32'd14 : 32'd0, !MD);
    op_check("remu", 4'd5, 32'd100, 32'd7,
             MD ? 32'd2 : 32'd0, !MD);
    op_check("divu0", 4'd4, 32'd9, 32'd0,
             MD ? 32'hFFFF_FFFF : 32'd0, !MD);
    op_check("remu0", 4'd5, 32'd9, 32'd0,
             MD ? 32'd9 : 32'd0, !MD);
    tick();

    // back-pressure on an OR result
    out_ready = 1'b0;
    issue("bp", 4'd1, 32'h0000_00F0, 32'h0000_000F);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_hold_out", out, 32'h0000_00FF);
      chk("bp_hold_rdy", in_ready, 0);
      tick();
    end
    out_ready = 1'b1;
    drive(1'b1, 4'd2, 32'd3, 32'd4);
    @(negedge clk);
    chk("bp_accept", in_ready, 1);
    tick();
    drive(1'b0, 4'd0, '0, '0);
    @(negedge clk);
    chk("bp_next", out, 32'd7);
    tick();

    // flush 10 cycles into MUL; inputs in flush cycle ignored
    issue("fl", 4'd3, 32'd3, 32'd5);
    seen = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (out_valid) seen++;
      tick();
    end
    flush = 1'b1;
    drive(1'b1, 4'd2, 32'd1, 32'd1);
    tick();
    flush = 1'b0;
    drive(1'b0, 4'd0, '0, '0);
    @(negedge clk);
    chk("flush_rdy", in_ready, 1);
    for (int i = 0; i < 40; i++) begin
      if (out_valid) seen++;
      @(negedge clk);
    end
    chk("flush_seen", seen, MD ? 0 : 1);
    tick();

    // reset in the middle of a MUL
    issue("rm", 4'd3, 32'd7, 32'd9);
    repeat (5) tick();
    rst_n = 1'b0;
    @(negedge clk);
    chk("rm_valid", out_valid, 0);
    chk("rm_out", out, 0);
    chk("rm_rdy", in_ready, 1);
    tick();
    rst_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    chk("rm_seen", seen, 0);
    tick();

    // randomized traffic
    for (int i = 0; i < 1500; i++) begin
      drive($urandom_range(0, 3) != 0,
            4'($urandom_range(0, 15)), rnd(), rnd());
      out_ready = ($urandom_range(0, 3) != 0);
      flush     = ($urandom_range(0, 60) == 0);
      tick();
    end
    drive(1'b0, 4'd0, '0, '0);
    flush     = 1'b0;
    out_ready = 1'b1;
    repeat (40) tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
